// File: rtl/demux1to4_stream_pkg.sv
// Shared lane constants and the select decode for the 1:4 stream demux.
// Optional broadcast support is enabled with DEMUX1TO4_BCAST_EN.
package demux1to4_stream_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  localparam logic [SEL_W-1:0] SEL_LANE0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_LANE1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_LANE2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_LANE3 = 2'b11;

  // One-hot destination lane for a select code.
  function automatic logic [NUM_LANES-1:0] lane_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_LANES-1:0] oh;
    oh = '0;
    case (sel)
      SEL_LANE0: oh = 4'b0001;
      SEL_LANE1: oh = 4'b0010;
      SEL_LANE2: oh = 4'b0100;
      SEL_LANE3: oh = 4'b1000;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux1to4_stream_if.sv
// Producer/consumer bundle of the 1:4 stream demux.
// bcast_in exists only when DEMUX1TO4_BCAST_EN is defined.
interface demux1to4_stream_if #(parameter int unsigned size = 8);

  logic [size-1:0] data_in;
  logic [1:0]      select_in;
  logic            valid_in;
  logic            ready_out;
  logic [size-1:0] data_out0;
  logic [size-1:0] data_out1;
  logic [size-1:0] data_out2;
  logic [size-1:0] data_out3;
  logic [3:0]      valid_out;
  logic [3:0]      ready_in;
`ifdef DEMUX1TO4_BCAST_EN
  logic            bcast_in;
`endif

  modport master (
    output data_in, select_in, valid_in, ready_in,
`ifdef DEMUX1TO4_BCAST_EN
    output bcast_in,
`endif
    input  ready_out, data_out0, data_out1, data_out2, data_out3, valid_out
  );

  modport slave (
    input  data_in, select_in, valid_in, ready_in,
`ifdef DEMUX1TO4_BCAST_EN
    input  bcast_in,
`endif
    output ready_out, data_out0, data_out1, data_out2, data_out3, valid_out
  );

endinterface

// File: rtl/demux1to4_stream_slot.sv
// One-entry holding register for one demux lane (valid/ready on the read side).
module demux_slot #(
  parameter int unsigned size = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [size-1:0] wr_data,
  input  logic            rd_ready,
  output logic [size-1:0] data_q,
  output logic            full_q
);

  logic [size-1:0] data_d;
  logic            full_d;

  // A write wins over a drain so drain+refill in one cycle keeps the slot full.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (wr_en) begin
      data_d = wr_data;
      full_d = 1'b1;
    end else if (full_q && rd_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/demux1to4_stream.sv
// Steers one producer stream into four independently stalled consumer lanes.
// Define DEMUX1TO4_BCAST_EN to add bcast_in (write all four lanes at once).
module demux1to4_stream
  import demux1to4_stream_pkg::*;
#(
  parameter int unsigned size = 8
) (
  input logic                clk,
  input logic                reset,
  demux1to4_stream_if.slave  bus
);

  logic [NUM_LANES-1:0] full_q;
  logic [NUM_LANES-1:0] lane_free_c;
  logic [NUM_LANES-1:0] wr_en_c;
  logic                 ready_c;
  logic                 accept_c;
  logic [size-1:0]      lane_data_q [NUM_LANES];

  // A lane can take a word if it is empty or being drained this cycle.
  always_comb begin
    lane_free_c = ~full_q | bus.ready_in;
    ready_c     = lane_free_c[bus.select_in];
    wr_en_c     = lane_decode(bus.select_in);
`ifdef DEMUX1TO4_BCAST_EN
    if (bus.bcast_in) begin
      ready_c = &lane_free_c;
      wr_en_c = '1;
    end
`endif
    accept_c = bus.valid_in & ready_c;
    wr_en_c  = wr_en_c & {NUM_LANES{accept_c}};
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_slot
    demux_slot #(.size(size)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en_c[k]),
      .wr_data  (bus.data_in),
      .rd_ready (bus.ready_in[k]),
      .data_q   (lane_data_q[k]),
      .full_q   (full_q[k])
    );
  end

  assign bus.ready_out = ready_c;
  assign bus.valid_out = full_q;
  assign bus.data_out0 = lane_data_q[0];
  assign bus.data_out1 = lane_data_q[1];
  assign bus.data_out2 = lane_data_q[2];
  assign bus.data_out3 = lane_data_q[3];

endmodule
